// File: rtl/decrypt_engine_iter.sv
// decrypt_engine_iter: multi-round key-tiled subtraction decryptor.
// Accepts {key, ciphertext y, pad}, runs ROUNDS rounds of y <= y - mask(r),
// one per clock, then holds the plaintext y[DATA_W:1] until the sink accepts it.
// Optional build macro: DECRYPT_LSB_CHECK_EN drives out_err from the final y[0];
// when undefined out_err is tied low and no check logic is built.

module decrypt_engine_iter #(
   parameter int unsigned KEY_W       = 11,
   parameter int unsigned DATA_W      = 60,
   parameter int unsigned PAD_W       = 6,
   parameter int unsigned ROUNDS      = 1,
   parameter logic [7:0]  INV_PATTERN = 8'b0001_0110
) (
   input  logic                             Clk,
   input  logic                             Rst,
   input  logic [KEY_W+DATA_W+1+PAD_W-1:0]  in_pkt,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_W-1:0]                out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_err,
   output logic                             busy
);

   localparam int unsigned PKT_W = KEY_W + DATA_W + 1 + PAD_W;
   localparam int unsigned Y_W   = DATA_W + 1;
   localparam logic [7:0]  LAST  = 8'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t          state;
   logic [7:0]      cnt;
   logic [KEY_W-1:0] key_r;
   logic [Y_W-1:0]  y_r;
   logic [Y_W-1:0]  mask;
   logic [Y_W-1:0]  y_next;
   logic            unused_bits;

   // Pad bits carry no information; y_next[0] only matters with the LSB check.
   assign unused_bits = ^{in_pkt[PAD_W-1:0], y_next[0]};

   // Tile the current round key across the word, inverting chunks per INV_PATTERN.
   always_comb begin
      mask = '0;
      for (int unsigned j = 0; j < Y_W; j++) begin
         mask[j] = key_r[j % KEY_W] ^ INV_PATTERN[(j / KEY_W) % 8];
      end
   end

   // One modular subtraction round; borrow out of the MSB is dropped.
   always_comb begin
      y_next = y_r - mask;
   end

   // Control FSM with registered handshake outputs and working registers.
   // key_r holds k_r directly: rotating by one each round equals rotating the
   // original key by (r mod KEY_W), since a KEY_W rotation is the identity.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         cnt       <= '0;
         key_r     <= '0;
         y_r       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
`ifdef DECRYPT_LSB_CHECK_EN
         out_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  key_r    <= in_pkt[PKT_W-1 -: KEY_W];
                  y_r      <= in_pkt[PAD_W +: Y_W];
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               y_r   <= y_next;
               key_r <= {key_r[KEY_W-2:0], key_r[KEY_W-1]};
               cnt   <= cnt + 8'd1;
               if (cnt == LAST) begin
                  out_data  <= y_next[DATA_W:1];
                  out_valid <= 1'b1;
`ifdef DECRYPT_LSB_CHECK_EN
                  out_err   <= y_next[0];
`endif
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef DECRYPT_LSB_CHECK_EN
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_decrypt_engine_iter.sv
// Scoreboard bench for decrypt_engine_iter: one instance with ROUNDS=1 and one
// with ROUNDS=3. Stimulus pushes expected results; per-instance monitors pop
// on each output handshake and also check accept-to-valid latency.

module tb_decrypt_engine_iter;

   localparam logic [7:0] INV = 8'b0001_0110;
`ifdef DECRYPT_LSB_CHECK_EN
   localparam bit LSB_EN = 1'b1;
`else
   localparam bit LSB_EN = 1'b0;
`endif

   typedef struct {
      logic [59:0] data;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic [77:0] pkt1, pkt3;
   logic        iv1, iv3, ir1, ir3, ov1, ov3, or1, or3, oe1, oe3, busy1, busy3;
   logic [59:0] od1, od3;

   exp_t        q1[$];
   exp_t        q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decrypt_engine_iter #(.ROUNDS(1)) u_dut1 (
      .Clk(clk), .Rst(rst), .in_pkt(pkt1), .in_valid(iv1), .in_ready(ir1),
      .out_data(od1), .out_valid(ov1), .out_ready(or1), .out_err(oe1), .busy(busy1)
   );

   decrypt_engine_iter #(.ROUNDS(3)) u_dut3 (
      .Clk(clk), .Rst(rst), .in_pkt(pkt3), .in_valid(iv3), .in_ready(ir3),
      .out_data(od3), .out_valid(ov3), .out_ready(or3), .out_err(oe3), .busy(busy3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference mask: rotate the key explicitly, then concatenate whole chunks.
   function automatic logic [60:0] ref_mask(input logic [10:0] key, input int r);
      logic [21:0] kk;
      logic [10:0] kr, ch;
      logic [65:0] m;
      kk = {key, key} << (r % 11);
      kr = kk[21:11];
      m  = '0;
      for (int i = 0; i < 6; i++) begin
         ch = INV[i % 8] ? ~kr : kr;
         m  = m | (66'(ch) << (11 * i));
      end
      return m[60:0];
   endfunction

   function automatic logic [60:0] ref_y(input logic [10:0] key, input logic [60:0] y, input int rounds);
      logic [60:0] yy;
      yy = y;
      for (int r = 0; r < rounds; r++) yy = yy - ref_mask(key, r);
      return yy;
   endfunction

   task automatic send(input int which, input logic [10:0] key, input logic [60:0] y,
                       input logic [59:0] exp_data, input logic exp_lsb);
      exp_t e;
      logic got;
      got = 1'b0;
      e.data = exp_data;
      e.err  = LSB_EN & exp_lsb;
      @(posedge clk); #1;
      if (which == 1) begin pkt1 = {key, y, 6'h2A}; iv1 = 1'b1; end
      else            begin pkt3 = {key, y, 6'h2A}; iv3 = 1'b1; end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         got = (which == 1) ? ir1 : ir3;
         if (got) break;
      end
      if (!got) begin
         chk("accept_timeout", 64'(got), 64'd1);
      end else begin
         e.acc = cyc + 1;
         if (which == 1) q1.push_back(e); else q3.push_back(e);
      end
      @(posedge clk); #1;
      if (which == 1) iv1 = 1'b0; else iv3 = 1'b0;
   endtask

   task automatic send_model(input int which, input logic [10:0] key, input logic [60:0] y);
      logic [60:0] yf;
      yf = ref_y(key, y, (which == 1) ? 1 : 3);
      send(which, key, y, yf[60:1], yf[0]);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (q1.size() == 0 && q3.size() == 0 && !ov1 && !ov3) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   // Monitor for the ROUNDS=1 instance.
   initial begin
      exp_t e;
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ov1 && !pv) begin
               if (q1.size() == 0) chk("stray_out1", 64'd1, 64'd0);
               else chk("latency1", 64'(cyc - q1[0].acc), 64'd1);
            end
            if (ov1 && or1 && q1.size() != 0) begin
               e = q1.pop_front();
               chk("data1", 64'(od1), 64'(e.data));
               chk("err1", 64'(oe1), 64'(e.err));
            end
         end
         pv = rst ? 1'b0 : ov1;
      end
   end

   // Monitor for the ROUNDS=3 instance.
   initial begin
      exp_t e;
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ov3 && !pv) begin
               if (q3.size() == 0) chk("stray_out3", 64'd1, 64'd0);
               else chk("latency3", 64'(cyc - q3[0].acc), 64'd3);
            end
            if (ov3 && or3 && q3.size() != 0) begin
               e = q3.pop_front();
               chk("data3", 64'(od3), 64'(e.data));
               chk("err3", 64'(oe3), 64'(e.err));
            end
         end
         pv = rst ? 1'b0 : ov3;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      pkt1 = '0; pkt3 = '0;
      iv1 = 1'b0; iv3 = 1'b0;
      or1 = 1'b1; or3 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ov1", 64'(ov1), 64'd0);
      chk("rst_od1", 64'(od1), 64'd0);
      chk("rst_busy1", 64'(busy1), 64'd0);
      chk("rst_err1", 64'(oe1), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ir1", 64'(ir1), 64'd1);
      chk("rst_ir3", 64'(ir3), 64'd1);

      // ROUNDS=1 hand-computed vectors
      send(1, 11'h000, 61'h7FF001FFFFF800, 60'h0, 1'b0);
      send(1, 11'h000, 61'h7FF001FFFFF802, 60'h1, 1'b0);
      send(1, 11'h000, 61'h7FF001FFFFF801, 60'h0, 1'b1);
      send(1, 11'h000, 61'h0, 60'hFC007FF00000400, 1'b0);
      send(1, 11'h001, 61'hFFE003FFBFF247, 60'h123, 1'b0);
      send_model(1, 11'h5A3, 61'h0123456789ABCDEF);
      drain();

      // Backpressure: hold out_ready low in HOLD and offer a second packet
      or1 = 1'b0;
      send(1, 11'h000, 61'h7FF001FFFFF802, 60'h1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         if (ov1) break;
         @(negedge clk);
      end
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 64'(ov1), 64'd1);
         chk("bp_data", 64'(od1), 64'h1);
         chk("bp_in_ready", 64'(ir1), 64'd0);
         if (c == 1) begin pkt1 = {11'h3C5, 61'h155, 6'h0}; iv1 = 1'b1; end
         if (c == 4) iv1 = 1'b0;
         @(negedge clk);
      end
      @(posedge clk); #1 or1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_ir_after", 64'(ir1), 64'd1);
      chk("bp_ov_after", 64'(ov1), 64'd0);
      chk("bp_busy_after", 64'(busy1), 64'd0);
      drain();

      // ROUNDS=3 vectors
      send(3, 11'h000, 61'h17FD005FFFFE800, 60'h0, 1'b0);
      send(3, 11'h000, 61'h17FD005FFFFE804, 60'h2, 1'b0);
      send_model(3, 11'h001, 61'h1ABCDEF012345678);
      send_model(3, 11'h7FF, 61'h0F0F0F0F0F0F0F0F);
      drain();

      // Reset mid-RUN discards the packet
      send(3, 11'h2B6, 61'h1234, 60'h0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_ov3", 64'(ov3), 64'd0);
      chk("midrst_od3", 64'(od3), 64'd0);
      chk("midrst_busy3", 64'(busy3), 64'd0);
      q3.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_ir3", 64'(ir3), 64'd1);
      repeat (10) @(negedge clk);
      chk("midrst_quiet", 64'(ov3), 64'd0);

      send(3, 11'h000, 61'h17FD005FFFFE804, 60'h2, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decrypt_engine_iter.md
Name: decrypt_engine_iter

Overview:
- Parametrised, multi-round successor to the single-step decrypt functions.
- Accepts one packet of {key, ciphertext, pad} and derives a key-tiled subtraction mask.
- Runs ROUNDS subtract-mask rounds, one per clock, then presents the plaintext.
- Sits between the packet deframer and the plaintext sink, with valid/ready handshakes on both sides.

Parameters:
- KEY_W, 11, key field width (bits).
- DATA_W, 60, plaintext width. The working ciphertext register is DATA_W+1 bits.
- PAD_W, 6, low packet pad bits; these are ignored.
- ROUNDS, 1, number of subtract rounds (1..255). Setting 1 gives the legacy single-step behaviour.
- INV_PATTERN, 8'b0001_0110, per-chunk inversion pattern. Chunk i is inverted when INV_PATTERN[i%8] is 1.

Ports:
- Clk  in  1  clock; rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- in_pkt  in  KEY_W+DATA_W+1+PAD_W  packet: [top KEY_W]=key, next DATA_W+1=ciphertext y, low PAD_W=ignored.
- in_valid  in  1  packet valid.
- in_ready  out  1  engine can accept a packet.
- out_data  out  DATA_W  decrypted plaintext.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_err  out  1  integrity flag (see Optional Feature).
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Reset (async, Rst=1): state=IDLE, round counter=0, working regs=0, out_data=0, out_valid=0, out_err=0, busy=0. in_ready=1 once Rst deasserts. Rst mid-RUN or mid-HOLD discards the packet with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch key and y, set cnt=0, go to RUN.
  - RUN: each cycle compute y <= y - mask(cnt) mod 2^(DATA_W+1), then cnt++. After the ROUNDS-th round go to HOLD.
  - HOLD: out_valid=1, out_data=y[DATA_W:1]. On out_ready, go to IDLE. out_data and out_err stay stable until accepted.
- in_ready is high only in IDLE; no new accept occurs in the cycle a HOLD handshake completes.
- Latency: accept at edge N; out_valid rises at edge N+ROUNDS. Throughput is 1 packet per ROUNDS+2 cycles when out_ready is held high.
- Mask rule for round r:
  - Key k_r = key rotated left by (r mod KEY_W).
  - Mask bits [KEY_W*i+KEY_W-1 : KEY_W*i] = INV_PATTERN[i%8] ? ~k_r : k_r.
  - The final partial chunk takes the low bits of the (possibly inverted) k_r.
  - The mask is zero-extended to DATA_W+1 bits.
- Arithmetic: unsigned, DATA_W+1 bits, modular. Borrow out of the MSB is discarded, with no flag.
- The LSB of the final y is dropped: out_data = y[DATA_W:1].
- in_pkt is sampled only on an IDLE handshake; changes at other times have no effect.

Optional Feature:
- Macro DECRYPT_LSB_CHECK_EN.
- Defined: on entering HOLD, out_err = final y[0], which must be 0 for a well-formed packet. out_err is held with out_data.
- Undefined: out_err is tied to 0 and no check logic is built.

Test Plan:
- Reset: assert Rst mid-RUN with ROUNDS=4 -> out_valid=0, out_data=0, busy=0 immediately. in_ready=1 after release. No stray output follows.
- Zero result: ROUNDS=1, key=11'h000, y=61'h7FF001FFFFF800, out_ready=1 -> out_data=60'h0 one cycle after accept; out_err=0.
- Unit value: key=0, y=61'h7FF001FFFFF802 -> out_data=60'h1, out_err=0. With y=61'h7FF001FFFFF801 -> out_data=0, and out_err=1 only when DECRYPT_LSB_CHECK_EN is defined.
- Wrap-around: key=0, y=0 -> internal y=61'h1F800FFE00000800, out_data=60'hFC007FF00000400.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held, out_data stable, in_ready=0, second in_valid ignored. Release -> accepted, IDLE next cycle.
- Multi-round: ROUNDS=3 -> out_valid exactly 3 cycles after accept. Result matches a reference model using rotated keys k_0, k_1, k_2.
